baud_gen_frac: RTL

Parametrised UART baud-rate generator for the CoreUARTapb family. It produces an oversampling tick (baud_tick) for the RX sampler and a bit-rate tick (xmit_tick) for the TX shifter. Divider width, oversampling ratio and fractional resolution are configurable. Fractional division uses an accumulator with period stretching, replacing fixed eighth-step tables. Adds enable gating and a phase-resync input.

---
 rtl/baud_gen_frac_if.sv | 26 ++
 rtl/baud_gen_frac.sv | 79 +++++++
 2 files changed

// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - control inputs and tick outputs of the fractional baud generator
interface baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 3,
  parameter int OVS    = 16
);
  localparam int PH_W = $clog2(OVS);

  logic              enable;
  logic              sync;
  logic [DIV_W-1:0]  baud_val;
  logic [FRAC_W-1:0] baud_frac;
  logic              baud_tick;
  logic              xmit_tick;
  logic [PH_W-1:0]   ovs_phase;

  modport master (
    output enable, sync, baud_val, baud_frac,
    input  baud_tick, xmit_tick, ovs_phase
  );

  modport slave (
    input  enable, sync, baud_val, baud_frac,
    output baud_tick, xmit_tick, ovs_phase
  );
endinterface

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - UART baud generator with fractional period stretching
// Emits an oversample tick every baud_val+1 clocks (plus one on accumulator carry) and a bit tick every OVS-th.
module baud_gen_frac #(
  parameter int DIV_W   = 16,
  parameter int FRAC_EN = 1,
  parameter int FRAC_W  = 3,
  parameter int OVS     = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  baud_gen_frac_if.slave bus
);
  localparam int              PH_W     = $clog2(OVS);
  localparam logic [PH_W-1:0] OVS_LAST = PH_W'(OVS - 1);
  localparam logic            FRAC_ON  = (FRAC_EN != 0);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              stretch_q, stretch_d;
  logic [PH_W-1:0]   ovs_cnt_q, ovs_cnt_d;
  logic              baud_tick_q, baud_tick_d;
  logic              xmit_tick_q, xmit_tick_d;
  logic [FRAC_W:0]   frac_sum;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    frac_acc_d  = frac_acc_q;
    stretch_d   = stretch_q;
    ovs_cnt_d   = ovs_cnt_q;
    baud_tick_d = 1'b0;
    xmit_tick_d = 1'b0;
    frac_sum    = '0;
    if (bus.sync || !bus.enable) begin
      div_cnt_d  = '0;
      frac_acc_d = '0;
      stretch_d  = 1'b0;
      ovs_cnt_d  = '0;
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end else if (stretch_q) begin
      // Carry from the previous reload: spend one extra idle clock here.
      stretch_d = 1'b0;
    end else begin
      div_cnt_d   = bus.baud_val;
      baud_tick_d = 1'b1;
      frac_sum    = {1'b0, frac_acc_q} + {1'b0, bus.baud_frac};
      frac_acc_d  = frac_sum[FRAC_W-1:0];
      stretch_d   = frac_sum[FRAC_W] & FRAC_ON;
      if (ovs_cnt_q == OVS_LAST) begin
        ovs_cnt_d   = '0;
        xmit_tick_d = 1'b1;
      end else begin
        ovs_cnt_d = ovs_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      frac_acc_q  <= '0;
      stretch_q   <= 1'b0;
      ovs_cnt_q   <= '0;
      baud_tick_q <= 1'b0;
      xmit_tick_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      frac_acc_q  <= frac_acc_d;
      stretch_q   <= stretch_d;
      ovs_cnt_q   <= ovs_cnt_d;
      baud_tick_q <= baud_tick_d;
      xmit_tick_q <= xmit_tick_d;
    end
  end

  assign bus.baud_tick = baud_tick_q;
  assign bus.xmit_tick = xmit_tick_q;
  assign bus.ovs_phase = ovs_cnt_q;
endmodule
